// File: rtl/io_pattern_checker.sv
// io_pattern_checker: drives a programmable pattern onto a bidirectional bus and checks the readback.
// Optional macro IOPC_INVERT_PASS_EN adds a bitwise-inverted replay pass before DONE.
module io_pattern_checker #(
    parameter int               WIDTH     = 8,
    parameter int               LEN_W     = 8,
    parameter int               ERR_W     = 8,
    parameter int               SETTLE    = 2,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(8'h01)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] pat_out,
    output logic [WIDTH-1:0] pat_oe,
    input  logic [WIDTH-1:0] pat_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [LEN_W-1:0] first_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_SAMPLE, ST_DONE} state_t;

    function automatic logic [WIDTH-1:0] checker_base();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH; i++) begin
            v[i] = ((i % 2) == 0);
        end
        return v;
    endfunction

    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CHECK0    = checker_base();
    localparam logic [WIDTH-1:0] SEED_EFF  = (LFSR_SEED == '0) ? ONE_W : LFSR_SEED;
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
    localparam logic [LEN_W-1:0] IDX_MSB   = {1'b1, {(LEN_W-1){1'b0}}};
    // With no settle time a vector is sampled in the very cycle it is first driven.
    localparam state_t           FIRST_ST  = (SETTLE == 0) ? ST_SAMPLE : ST_DRIVE;

    function automatic logic [WIDTH-1:0] gen_first(input logic [1:0] m);
        case (m)
            2'd0:    return '0;
            2'd1:    return ONE_W;
            2'd2:    return SEED_EFF;
            2'd3:    return CHECK0;
            default: return '0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] gen_next(input logic [1:0] m, input logic [WIDTH-1:0] g);
        case (m)
            2'd0:    return g + ONE_W;
            2'd1:    return {g[WIDTH-2:0], g[WIDTH-1]};
            2'd2:    return (g >> 1) ^ (g[0] ? LFSR_TAPS : '0);
            2'd3:    return ~g;
            default: return g;
        endcase
    endfunction

    state_t           state_r, state_nx_s;
    logic [1:0]       mode_lat_r;
    logic [LEN_W-1:0] len_lat_r, idx_r, first_err_r;
    logic [3:0]       settle_r;
    logic [WIDTH-1:0] gen_r, expect_s, pat_out_r, pat_oe_r;
    logic [ERR_W-1:0] err_count_r;
    logic             busy_r, done_r, pass_r;
    logic             mismatch_s, last_vec_s, inv_s, more_pass_s;

    assign last_vec_s = (idx_r == (len_lat_r - LEN_W'(1)));
    assign expect_s   = gen_r ^ {WIDTH{inv_s}};

`ifdef IOPC_INVERT_PASS_EN
    logic inv_r;
    // Marks the inverted replay pass; cleared on every accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_r <= 1'b0;
        end else if (ena) begin
            if (state_r == ST_IDLE && start) begin
                inv_r <= 1'b0;
            end else if (state_r == ST_SAMPLE && last_vec_s && !inv_r) begin
                inv_r <= 1'b1;
            end
        end
    end
    assign inv_s       = inv_r;
    assign more_pass_s = ~inv_r;
`else
    assign inv_s       = 1'b0;
    assign more_pass_s = 1'b0;
`endif

    // Next-state decode and readback comparison.
    always_comb begin
        state_nx_s = state_r;
        mismatch_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) state_nx_s = ST_DONE;
                    else           state_nx_s = FIRST_ST;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (settle_r == SETTLE_LAST) state_nx_s = ST_SAMPLE;
                else                         state_nx_s = ST_DRIVE;
            end
            ST_SAMPLE: begin
                mismatch_s = (pat_in != expect_s);
                if (last_vec_s && !more_pass_s) state_nx_s = ST_DONE;
                else                            state_nx_s = FIRST_ST;
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, generator, result and output registers; everything holds while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mode_lat_r  <= 2'd0;
            len_lat_r   <= '0;
            idx_r       <= '0;
            settle_r    <= 4'd0;
            gen_r       <= '0;
            pat_out_r   <= '0;
            pat_oe_r    <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_count_r <= '0;
            first_err_r <= '1;
        end else if (ena) begin
            state_r <= state_nx_s;
            busy_r  <= (state_r == ST_DRIVE) || (state_r == ST_SAMPLE);
            done_r  <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_lat_r  <= mode;
                        len_lat_r   <= len;
                        idx_r       <= '0;
                        settle_r    <= 4'd0;
                        gen_r       <= gen_first(mode);
                        err_count_r <= '0;
                        first_err_r <= '1;
                        pass_r      <= 1'b0;
                        if (len != '0) begin
                            pat_out_r <= gen_first(mode);
                            pat_oe_r  <= '1;
                        end
                    end
                end
                ST_DRIVE: settle_r <= settle_r + 4'd1;
                ST_SAMPLE: begin
                    settle_r <= 4'd0;
                    if (mismatch_s) begin
                        if (err_count_r != ERR_MAX) err_count_r <= err_count_r + ERR_W'(1);
                        if (first_err_r == '1) first_err_r <= inv_s ? (idx_r & ~IDX_MSB) : idx_r;
                    end
                    if (last_vec_s && !more_pass_s) begin
                        pat_out_r <= '0;
                        pat_oe_r  <= '0;
                    end else if (last_vec_s) begin
                        idx_r     <= '0;
                        gen_r     <= gen_first(mode_lat_r);
                        pat_out_r <= ~gen_first(mode_lat_r);
                    end else begin
                        idx_r     <= idx_r + LEN_W'(1);
                        gen_r     <= gen_next(mode_lat_r, gen_r);
                        pat_out_r <= gen_next(mode_lat_r, gen_r) ^ {WIDTH{inv_s}};
                    end
                end
                ST_DONE: pass_r <= (err_count_r == '0);
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign pat_out   = pat_out_r;
    assign pat_oe    = pat_oe_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_count_r;
    assign first_err = first_err_r;

endmodule
